// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Resolves the branch outcome (PCAsrc/PCBsrc) from the 3-bit Branch code and
//   the ALU flags, predicts conditional branches at fetch with a PC-indexed
//   table of saturating counters (BHT), trains that table on resolution, flags
//   mispredictions and keeps saturating branch / mispredict statistics.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst_n            : asynchronous active-low reset
//   pc_f             : fetch PC to predict
//   pred_taken       : prediction for pc_f (MSB of the indexed counter)
//   res_valid        : resolve-stage branch info valid this cycle
//   res_pc           : PC of the resolving instruction
//   Branch           : 000 none, 001 jal, 010 jalr, 100 beq, 101 bne,
//                      110 blt, 111 bge, 011 reserved
//   zero, less       : ALU flags
//   res_pred         : prediction originally issued for this instruction
//   clear_stats      : synchronous clear of the statistics counters
//   PCAsrc           : actual taken, select branch target
//   PCBsrc           : jalr, target base comes from a register
//   mispredict       : combinational redirect request
//   mispredict_q     : mispredict registered one cycle (flush pulse)
//   stat_branches    : resolved conditional branches
//   stat_mispredicts : mispredicted conditional branches
module branch_predict_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int IDX_BITS   = 6,
  parameter int CNT_WIDTH  = 2,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   pc_f,
  output logic                  pred_taken,
  input  logic                  res_valid,
  input  logic [PC_WIDTH-1:0]   res_pc,
  input  logic [2:0]            Branch,
  input  logic                  zero,
  input  logic                  less,
  input  logic                  res_pred,
  input  logic                  clear_stats,
  output logic                  PCAsrc,
  output logic                  PCBsrc,
  output logic                  mispredict,
  output logic                  mispredict_q,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  // Weakly not-taken: 0111..1
  localparam logic [CNT_WIDTH-1:0]  CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0]  bht_q [ENTRIES];
  logic [IDX_BITS-1:0]   predIdx;
  logic [IDX_BITS-1:0]   resIdx;
  logic [CNT_WIDTH-1:0]  cntCur;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  trainEn;
  logic [STAT_WIDTH-1:0] branches_q, branches_d;
  logic [STAT_WIDTH-1:0] mispredicts_q, mispredicts_d;

  // PC bits outside the index field are deliberately ignored (aliasing).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[PC_WIDTH-1:IDX_BITS+2], pc_f[1:0],
                            res_pc[PC_WIDTH-1:IDX_BITS+2], res_pc[1:0]};

  assign predIdx = pc_f[IDX_BITS+1:2];
  assign resIdx  = res_pc[IDX_BITS+1:2];

  // Read port has no bypass: a same-cycle write is seen only after the edge.
  assign pred_taken = bht_q[predIdx][CNT_WIDTH-1];

  always_comb begin
    PCAsrc = 1'b0;
    unique case (Branch)
      3'b001, 3'b010: PCAsrc = 1'b1;
      3'b100:         PCAsrc = zero;
      3'b101:         PCAsrc = ~zero;
      3'b110:         PCAsrc = less;
      3'b111:         PCAsrc = ~less;
      default:        PCAsrc = 1'b0;
    endcase
  end

  assign PCBsrc = (Branch == 3'b010);

  // jalr always redirects since its target is unknown at fetch.
  assign mispredict = res_valid & ((PCAsrc ^ res_pred) | PCBsrc);

  // Only conditional codes (Branch[2] set) train and are counted.
  assign trainEn = res_valid & Branch[2];

  assign cntCur = bht_q[resIdx];

  always_comb begin
    cnt_d = cntCur;
    if (PCAsrc) begin
      if (cntCur != CNT_MAX) cnt_d = cntCur + CNT_ONE;
    end else begin
      if (cntCur != '0) cnt_d = cntCur - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else if (trainEn) begin
      bht_q[resIdx] <= cnt_d;
    end
  end

  // Clear wins over a simultaneous increment; both counters saturate.
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (clear_stats) begin
      branches_d    = '0;
      mispredicts_d = '0;
    end else if (trainEn) begin
      if (branches_q != STAT_MAX) branches_d = branches_q + STAT_ONE;
      if (mispredict && (mispredicts_q != STAT_MAX))
        mispredicts_d = mispredicts_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
      mispredict_q  <= 1'b0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
      mispredict_q  <= mispredict;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  Branch;
  logic        zero;
  logic        less;
  logic        res_pred;
  logic        clear_stats;
  logic        PCAsrc;
  logic        PCBsrc;
  logic        mispredict;
  logic        mispredict_q;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checkCount;
  int failCount;

  branch_predict_unit #(
    .PC_WIDTH(32), .IDX_BITS(6), .CNT_WIDTH(2), .STAT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .Branch(Branch),
    .zero(zero), .less(less), .res_pred(res_pred),
    .clear_stats(clear_stats), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc),
    .mispredict(mispredict), .mispredict_q(mispredict_q),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives the resolve-stage inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [2:0] br, input logic z,
                               input logic l, input logic p);
    res_valid = v;
    res_pc    = pc;
    Branch    = br;
    zero      = z;
    less      = l;
    res_pred  = p;
  endtask

  // Advances to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount  = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    pc_f        = 32'h100;
    clear_stats = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Reset state
    #2;
    checkOutput("rst_pred", {31'b0, pred_taken}, 32'd0);
    checkOutput("rst_mq", {31'b0, mispredict_q}, 32'd0);
    checkOutput("rst_sb", stat_branches, 32'd0);
    checkOutput("rst_sm", stat_mispredicts, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();

    // Decode sweep (res_pc 0x80 -> index 32, unused later)
    applyStimulus(1'b1, 32'h80, 3'b100, 1'b1, 1'b0, 1'b0); #1;
    checkOutput("beq_a", {31'b0, PCAsrc}, 32'd1);
    checkOutput("beq_m", {31'b0, mispredict}, 32'd1);
    checkOutput("beq_b", {31'b0, PCBsrc}, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b101, 1'b1, 1'b0, 1'b0); #1;
    checkOutput("bne_a", {31'b0, PCAsrc}, 32'd0);
    checkOutput("bne_m", {31'b0, mispredict}, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b110, 1'b0, 1'b1, 1'b0); #1;
    checkOutput("blt_a", {31'b0, PCAsrc}, 32'd1);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b111, 1'b0, 1'b1, 1'b0); #1;
    checkOutput("bge_a", {31'b0, PCAsrc}, 32'd0);
    checkOutput("bge_m", {31'b0, mispredict}, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b010, 1'b0, 1'b0, 1'b0); #1;
    checkOutput("jalr_a", {31'b0, PCAsrc}, 32'd1);
    checkOutput("jalr_b", {31'b0, PCBsrc}, 32'd1);
    checkOutput("jalr_m", {31'b0, mispredict}, 32'd1);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b001, 1'b0, 1'b0, 1'b0); #1;
    checkOutput("jal_a", {31'b0, PCAsrc}, 32'd1);
    checkOutput("jal_b", {31'b0, PCBsrc}, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b011, 1'b1, 1'b1, 1'b0); #1;
    checkOutput("rsv_a", {31'b0, PCAsrc}, 32'd0);
    checkOutput("rsv_m", {31'b0, mispredict}, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 3'b000, 1'b0, 1'b0, 1'b1); #1;
    checkOutput("none_pred_m", {31'b0, mispredict}, 32'd1);
    stepCycle();
    applyStimulus(1'b0, 32'h80, 3'b010, 1'b0, 1'b0, 1'b0); #1;
    checkOutput("inval_m", {31'b0, mispredict}, 32'd0);
    checkOutput("inval_a", {31'b0, PCAsrc}, 32'd1);
    stepCycle();

    // Training at res_pc 0x40 (index 16)
    pc_f = 32'h40;
    applyStimulus(1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0); #1;
    checkOutput("tr_init", {31'b0, pred_taken}, 32'd0);
    stepCycle(); checkOutput("tr_t1", {31'b0, pred_taken}, 32'd1);  // 10
    stepCycle(); checkOutput("tr_t2", {31'b0, pred_taken}, 32'd1);  // 11
    stepCycle(); checkOutput("tr_t3", {31'b0, pred_taken}, 32'd1);  // 11
    applyStimulus(1'b1, 32'h40, 3'b100, 1'b0, 1'b0, 1'b0);
    stepCycle(); checkOutput("tr_n1", {31'b0, pred_taken}, 32'd1);  // 10
    stepCycle(); checkOutput("tr_n2", {31'b0, pred_taken}, 32'd0);  // 01
    stepCycle(); checkOutput("tr_n3", {31'b0, pred_taken}, 32'd0);  // 00
    stepCycle(); checkOutput("tr_n4", {31'b0, pred_taken}, 32'd0);  // 00
    applyStimulus(1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0);
    stepCycle(); checkOutput("tr_u1", {31'b0, pred_taken}, 32'd0);  // 01
    stepCycle(); checkOutput("tr_u2", {31'b0, pred_taken}, 32'd1);  // 10
    applyStimulus(1'b1, 32'h40, 3'b100, 1'b0, 1'b0, 1'b0);
    stepCycle(); checkOutput("tr_back", {31'b0, pred_taken}, 32'd0); // 01

    // Aliasing: 0x140 maps to index 16 as well
    applyStimulus(1'b1, 32'h140, 3'b100, 1'b1, 1'b0, 1'b0); #1;
    checkOutput("alias_same", {31'b0, pred_taken}, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("alias_next", {31'b0, pred_taken}, 32'd1);

    // Statistics (res_pc 0xC0 -> index 48)
    clear_stats = 1'b1;
    stepCycle();
    clear_stats = 1'b0;
    checkOutput("clr0_sb", stat_branches, 32'd0);
    checkOutput("clr0_sm", stat_mispredicts, 32'd0);
    applyStimulus(1'b1, 32'hC0, 3'b100, 1'b1, 1'b0, 1'b1); stepCycle();
    applyStimulus(1'b1, 32'hC0, 3'b101, 1'b1, 1'b0, 1'b0); stepCycle();
    applyStimulus(1'b1, 32'hC0, 3'b110, 1'b0, 1'b1, 1'b0); stepCycle();
    checkOutput("mq_pulse", {31'b0, mispredict_q}, 32'd1);
    applyStimulus(1'b1, 32'hC0, 3'b001, 1'b0, 1'b0, 1'b1); stepCycle();
    checkOutput("mq_drop", {31'b0, mispredict_q}, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("st_sb", stat_branches, 32'd3);
    checkOutput("st_sm", stat_mispredicts, 32'd1);
    clear_stats = 1'b1;
    applyStimulus(1'b1, 32'hC0, 3'b100, 1'b1, 1'b0, 1'b0); stepCycle();
    clear_stats = 1'b0;
    checkOutput("clr_sb", stat_branches, 32'd0);
    checkOutput("clr_sm", stat_mispredicts, 32'd0);
    checkOutput("clr_mq", {31'b0, mispredict_q}, 32'd1);

    // Async reset mid-run after training index 16 to 11
    applyStimulus(1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0); stepCycle();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_pred", {31'b0, pred_taken}, 32'd1);
    checkOutput("pre_rst_sb", stat_branches, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_pred", {31'b0, pred_taken}, 32'd0);
    checkOutput("arst_sb", stat_branches, 32'd0);
    checkOutput("arst_sm", stat_mispredicts, 32'd0);
    checkOutput("arst_mq", {31'b0, mispredict_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0); stepCycle();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_pred", {31'b0, pred_taken}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
